// File: rtl/twiddle_gen.sv
// Twiddle-factor sequencer for one radix-2 SDF FFT stage: 4L-sample frame schedule,
// quarter-wave cosine table, registered outputs. Define TWIDDLE_INV_EN for inverse mode.
module twiddle_gen #(
  parameter int L     = 32,
  parameter int WIDTH = 24,
  parameter int FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    inv,
  output logic signed [WIDTH-1:0] w_r,
  output logic signed [WIDTH-1:0] w_i,
  output logic [1:0]              state,
  output logic                    w_valid,
  output logic                    frame_done
);

  localparam int CW   = $clog2(4 * L);
  localparam int LW   = $clog2(L);
  localparam int HALF = L / 2;
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << FRAC);

  // C[m] = round(2^FRAC * cos(pi*m/L)); non-negative over 0..L/2, so +0.5 then truncate
  function automatic int qcos(input int m);
    real x;
    x = real'(1 << FRAC) * $cos(3.14159265358979323846 * real'(m) / real'(L));
    return $rtoi(x + 0.5);
  endfunction

  logic signed [WIDTH-1:0] w_tab [0:HALF];

  for (genvar m = 0; m <= HALF; m++) begin : g_tab
    localparam int CV = qcos(m);
    assign w_tab[m] = WIDTH'(CV);
  end

  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic          w_adv;
  logic          w_last;
  logic          w_inv;
  logic [1:0]    w_phase;
  logic [LW-1:0] w_k;
  logic          w_hi;
  logic [LW-1:0] w_ic;
  logic [LW-1:0] w_is;
  logic signed [WIDTH-1:0] w_cos;
  logic signed [WIDTH-1:0] w_sin;
  logic signed [WIDTH-1:0] w_tw_r;
  logic signed [WIDTH-1:0] w_tw_i;

  assign w_adv   = in_valid | r_run;
  assign w_last  = &r_cnt;
  assign w_phase = r_cnt[CW-1 -: 2];
  assign w_k     = r_cnt[LW-1:0];
  assign w_hi    = w_k[LW-1];

  // Second quarter folds back onto the table: cos(k) = -C[L-k], sin(k) = C[k-L/2]
  always_comb begin
    w_ic = w_k;
    w_is = LW'(HALF) - w_k;
    if (w_hi) begin
      w_ic = -w_k;
      w_is = w_k - LW'(HALF);
    end
  end

  assign w_cos = w_hi ? -w_tab[w_ic] : w_tab[w_ic];
  assign w_sin = w_tab[w_is];

  always_comb begin
    w_tw_r = ONE;
    w_tw_i = '0;
    if (w_phase == 2'd2) begin
      w_tw_r = w_cos;
      w_tw_i = w_inv ? w_sin : -w_sin;
    end
  end

`ifdef TWIDDLE_INV_EN
  logic r_inv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inv_q <= 1'b0;
    end else if (w_adv && r_cnt == '0) begin
      r_inv_q <= inv;
    end
  end

  assign w_inv = r_inv_q;
`else
  logic w_unused;

  assign w_unused = inv;
  assign w_inv    = 1'b0;
`endif

  // Output stage: registers describe the pre-advance index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_run      <= 1'b0;
      w_r        <= ONE;
      w_i        <= '0;
      state      <= 2'd0;
      w_valid    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      w_valid    <= w_adv;
      frame_done <= w_adv & w_last;
      if (w_adv) begin
        r_cnt <= r_cnt + CW'(1);
        w_r   <= w_tw_r;
        w_i   <= w_tw_i;
        state <= w_phase;
      end
      if (in_valid) begin
        r_run <= 1'b1;
      end else if (w_adv && w_last) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Bench for twiddle_gen (L=32, FRAC=8): behavioural model from exp(-j*2*pi*k/2L) plus literal pins.
module tb_twiddle_gen;
  localparam int L     = 32;
  localparam int WIDTH = 24;
  localparam int FRAC  = 8;
  localparam int N4    = 4 * L;

  logic clk;
  logic rst;
  logic in_valid;
  logic inv;
  logic signed [WIDTH-1:0] w_r;
  logic signed [WIDTH-1:0] w_i;
  logic [1:0] state;
  logic w_valid;
  logic frame_done;

  twiddle_gen #(.L(L), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inv(inv),
    .w_r(w_r), .w_i(w_i), .state(state), .w_valid(w_valid), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int fd_cnt  = 0;
  int wv_low  = 0;
  int lit_mode = 0;

  // model state
  int m_cnt = 0;
  bit m_run = 0;
  bit m_inv = 0;
  bit m_init = 0;
  bit adv;
  int e_wr = 256, e_wi = 0, e_st = 0, e_c = 0;
  bit e_wv = 0, e_fd = 0;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (c=%0d, t=%0t)", nm, act, exp, e_c, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_run = 0; m_inv = 0; m_init = 1;
      e_wr = 1 << FRAC; e_wi = 0; e_st = 0; e_wv = 0; e_fd = 0; e_c = 0;
    end else begin
      adv  = in_valid || m_run;
      e_wv = adv;
      e_fd = 0;
      if (adv) begin
`ifdef TWIDDLE_INV_EN
        if (m_cnt == 0) m_inv = inv;
`endif
        e_c  = m_cnt;
        e_st = m_cnt / L;
        e_fd = (m_cnt == N4 - 1);
        if (e_st == 2) begin
          real ang;
          int  s;
          ang  = 2.0 * 3.14159265358979323846 * real'(m_cnt % L) / real'(2 * L);
          e_wr = rnd(real'(1 << FRAC) * $cos(ang));
          s    = rnd(real'(1 << FRAC) * $sin(ang));
          e_wi = m_inv ? s : -s;
        end else begin
          e_wr = 1 << FRAC;
          e_wi = 0;
        end
        if (!in_valid && m_cnt == N4 - 1) m_run = 0;
        m_cnt = (m_cnt + 1) % N4;
      end
      if (in_valid) m_run = 1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("w_r", w_r, e_wr);
      chk("w_i", w_i, e_wi);
      chk("state", state, e_st);
      chk("w_valid", w_valid, e_wv);
      chk("frame_done", frame_done, e_fd);
      if (frame_done === 1'b1) fd_cnt++;
      if (w_valid !== 1'b1) wv_low++;
      if (e_wv && lit_mode == 1) begin
        case (e_c)
          0:  chk("lit_state_c0", state, 0);
          10: chk("lit_wr_c10", w_r, 256);
          32: chk("lit_state_c32", state, 1);
          64: chk("lit_state_c64", state, 2);
          65: begin chk("lit_wr_c65", w_r, 255); chk("lit_wi_c65", w_i, -25); end
          72: begin chk("lit_wr_c72", w_r, 181); chk("lit_wi_c72", w_i, -181); end
          80: begin chk("lit_wr_c80", w_r, 0); chk("lit_wi_c80", w_i, -256); end
          95: begin chk("lit_wr_c95", w_r, -255); chk("lit_wi_c95", w_i, -25); end
          96: chk("lit_state_c96", state, 3);
          100: begin chk("lit_wr_c100", w_r, 256); chk("lit_wi_c100", w_i, 0); end
          default: ;
        endcase
      end
      if (e_wv && lit_mode == 2) begin
        case (e_c)
          65: begin chk("lit_inv_wr_c65", w_r, 255); chk("lit_inv_wi_c65", w_i, 25); end
          72: chk("lit_inv_wi_c72", w_i, 181);
          default: ;
        endcase
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_w_r"}, w_r, 256);
    chk({tag, "_w_i"}, w_i, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_w_valid"}, w_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; inv = 1'b0;
    cycles(3);
    chk_reset_outputs("rst");
    rst = 1'b0;
    cycles(2);

    // forward frame of 128 pulses, then flush of the following frame
    lit_mode = 1;
    in_valid = 1'b1;
    cycles(128);
    in_valid = 1'b0;
    cycles(140);
    lit_mode = 0;

`ifdef TWIDDLE_INV_EN
    inv = 1'b1;
    lit_mode = 2;
    in_valid = 1'b1;
    cycles(70);
    inv = 1'b0;
    cycles(58);
    lit_mode = 0;
    in_valid = 1'b0;
    cycles(140);
`endif

    // single pulse flushes one frame on its own
    fd_cnt = 0;
    in_valid = 1'b1;
    cycles(1);
    in_valid = 1'b0;
    cycles(140);
    chk("single_fd_count", fd_cnt, 1);
    chk("single_idle_wv", w_valid, 0);

    // two back-to-back frames
    fd_cnt = 0;
    in_valid = 1'b1;
    cycles(1);
    wv_low = 0;
    cycles(255);
    chk("b2b_no_bubble", wv_low, 0);
    cycles(1);
    in_valid = 1'b0;
    cycles(2);
    chk("b2b_fd_count", fd_cnt, 2);
    cycles(140);

    // reset mid-frame at c=80, then restart
    in_valid = 1'b1;
    cycles(80);
    rst = 1'b1;
    cycles(1);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    cycles(1);
    chk("restart_state", state, 0);
    chk("restart_wv", w_valid, 1);
    chk("restart_wr", w_r, 256);
    in_valid = 1'b0;
    cycles(140);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      inv      = $urandom_range(0, 1) == 1;
      rst      = ($urandom_range(0, 299) == 0);
      cycles(1);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    cycles(140);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
